// File: rtl/tl_ad_channel_buffer.sv
// Registered A/D channel buffer for one TileLink master port: two independent circular FIFOs.
// Optional flow-through-when-empty mode is enabled by defining TL_AD_BUFFER_FLOW_EN.

module tl_ad_fifo #(
  parameter int unsigned DEPTH = 2,
  parameter int unsigned WIDTH = 8
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_bits,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_bits,
  output logic [3:0]       occupancy
);
  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam logic [3:0] FULL_COUNT = 4'(DEPTH);

  logic [WIDTH-1:0] storage [DEPTH];
  logic [PTR_W-1:0] enq_ptr;
  logic [PTR_W-1:0] deq_ptr;
  logic [3:0]       count;
  logic             empty;
  logic             enq;
  logic             deq;

  assign empty     = (count == 4'd0);
  assign in_ready  = (count != FULL_COUNT) & ~reset;
  assign occupancy = count;

`ifdef TL_AD_BUFFER_FLOW_EN
  // An empty queue forwards the incoming beat; it is only stored if not taken this cycle.
  logic bypass;
  assign bypass    = empty & in_valid & out_ready;
  assign out_valid = (~empty | in_valid) & ~reset;
  assign out_bits  = empty ? in_bits : storage[deq_ptr];
  assign enq       = in_valid & in_ready & ~bypass;
  assign deq       = ~empty & out_ready;
`else
  assign out_valid = ~empty;
  assign out_bits  = storage[deq_ptr];
  assign enq       = in_valid & in_ready;
  assign deq       = out_valid & out_ready;
`endif

  // Pointer and occupancy state
  always_ff @(posedge clock) begin
    if (reset) begin
      enq_ptr <= '0;
      deq_ptr <= '0;
      count   <= '0;
    end else begin
      if (enq) enq_ptr <= enq_ptr + PTR_W'(1);
      if (deq) deq_ptr <= deq_ptr + PTR_W'(1);
      if (enq && !deq)      count <= count + 4'd1;
      else if (deq && !enq) count <= count - 4'd1;
    end
  end

  // Payload storage is deliberately left unreset
  always_ff @(posedge clock) begin
    if (enq) storage[enq_ptr] <= in_bits;
  end
endmodule

module tl_ad_channel_buffer #(
  parameter int unsigned A_DEPTH = 2,
  parameter int unsigned D_DEPTH = 2
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         a_in_valid,
  output logic         a_in_ready,
  input  logic [118:0] a_in_bits,
  output logic         a_out_valid,
  input  logic         a_out_ready,
  output logic [118:0] a_out_bits,
  input  logic         d_in_valid,
  output logic         d_in_ready,
  input  logic [78:0]  d_in_bits,
  output logic         d_out_valid,
  input  logic         d_out_ready,
  output logic [78:0]  d_out_bits,
  output logic [3:0]   a_occupancy,
  output logic [3:0]   d_occupancy
);
  localparam int unsigned A_W = 119;
  localparam int unsigned D_W = 79;

  tl_ad_fifo #(.DEPTH(A_DEPTH), .WIDTH(A_W)) u_a_fifo (
    .clock     (clock),
    .reset     (reset),
    .in_valid  (a_in_valid),
    .in_ready  (a_in_ready),
    .in_bits   (a_in_bits),
    .out_valid (a_out_valid),
    .out_ready (a_out_ready),
    .out_bits  (a_out_bits),
    .occupancy (a_occupancy)
  );

  tl_ad_fifo #(.DEPTH(D_DEPTH), .WIDTH(D_W)) u_d_fifo (
    .clock     (clock),
    .reset     (reset),
    .in_valid  (d_in_valid),
    .in_ready  (d_in_ready),
    .in_bits   (d_in_bits),
    .out_valid (d_out_valid),
    .out_ready (d_out_ready),
    .out_bits  (d_out_bits),
    .occupancy (d_occupancy)
  );
endmodule

// File: tb/tb_tl_ad_channel_buffer.sv
// Self-checking bench for tl_ad_channel_buffer: directed vector table, corner sequences, random scoreboard.
module tb_tl_ad_channel_buffer;
  localparam int AD = 2;
  localparam int DD = 2;

  logic         clock;
  logic         reset;
  logic         a_in_valid, a_in_ready, a_out_valid, a_out_ready;
  logic [118:0] a_in_bits, a_out_bits;
  logic         d_in_valid, d_in_ready, d_out_valid, d_out_ready;
  logic [78:0]  d_in_bits, d_out_bits;
  logic [3:0]   a_occupancy, d_occupancy;

  int n_checks;
  int n_fail;

  tl_ad_channel_buffer #(.A_DEPTH(AD), .D_DEPTH(DD)) dut (
    .clock       (clock),
    .reset       (reset),
    .a_in_valid  (a_in_valid),
    .a_in_ready  (a_in_ready),
    .a_in_bits   (a_in_bits),
    .a_out_valid (a_out_valid),
    .a_out_ready (a_out_ready),
    .a_out_bits  (a_out_bits),
    .d_in_valid  (d_in_valid),
    .d_in_ready  (d_in_ready),
    .d_in_bits   (d_in_bits),
    .d_out_valid (d_out_valid),
    .d_out_ready (d_out_ready),
    .d_out_bits  (d_out_bits),
    .a_occupancy (a_occupancy),
    .d_occupancy (d_occupancy)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      if (n_fail <= 40) $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  // A Get beat: opcode 4, size 3, full mask, address 0x8000_0000 + 8*source
  function automatic logic [118:0] mk_a(input logic [3:0] src);
    logic [31:0] addr;
    addr = 32'h8000_0000 + 32'(src) * 32'd8;
    return {1'b0, 64'hA5A5_0000_0000_0000 | 64'(src), 8'hFF, addr, src, 4'd3, 3'd0, 3'd4};
  endfunction

  // AccessAckData beat carrying the given data word
  function automatic logic [78:0] mk_d(input logic [63:0] data);
    return {1'b0, data, 1'b0, 4'h1, 4'd3, 2'd0, 3'd1};
  endfunction

  typedef struct {
    logic       rst;
    logic       av;
    logic       ar;
    logic [3:0] src;
    logic       e_rdy;
    logic       e_vld;
    logic [3:0] e_occ;
    logic [3:0] e_src;
  } vec_t;

  function automatic vec_t mkv(input logic rst, av, ar, input logic [3:0] src,
                               input logic e_rdy, e_vld, input logic [3:0] e_occ, e_src);
    vec_t v;
    v.rst = rst; v.av = av; v.ar = ar; v.src = src;
    v.e_rdy = e_rdy; v.e_vld = e_vld; v.e_occ = e_occ; v.e_src = e_src;
    return v;
  endfunction

  vec_t tbl [11];
  logic [118:0] qa [$];
  logic [78:0]  qd [$];

  initial begin
    logic [118:0] ea_bits, pa_bits;
    logic [78:0]  ed_bits, pd_bits;
    logic         ea_vld, ed_vld, pa_vld, pa_rdy, pd_vld, pd_rdy;
    logic [63:0]  dbase;

    n_checks = 0;
    n_fail   = 0;
    reset = 1'b1;
    a_in_valid = 1'b0; a_out_ready = 1'b0; a_in_bits = '0;
    d_in_valid = 1'b0; d_out_ready = 1'b0; d_in_bits = '0;
    step();
    step();

    // Rows: rst av ar src | rdy vld occ src
    tbl[0]  = mkv(1, 0, 0, 0, 0, 0, 0, 0);
    tbl[1]  = mkv(0, 0, 0, 0, 1, 0, 0, 0);
    tbl[2]  = mkv(0, 1, 0, 0, 1, 0, 0, 0);
    tbl[3]  = mkv(0, 1, 0, 1, 1, 1, 1, 0);
    tbl[4]  = mkv(0, 1, 0, 2, 0, 1, 2, 0);
    tbl[5]  = mkv(0, 1, 0, 2, 0, 1, 2, 0);
    tbl[6]  = mkv(0, 1, 1, 2, 0, 1, 2, 0);
    tbl[7]  = mkv(0, 1, 0, 2, 1, 1, 1, 1);
    tbl[8]  = mkv(0, 0, 1, 0, 0, 1, 2, 1);
    tbl[9]  = mkv(0, 0, 1, 0, 1, 1, 1, 2);
    tbl[10] = mkv(0, 0, 0, 0, 1, 0, 0, 0);
`ifdef TL_AD_BUFFER_FLOW_EN
    tbl[2].e_vld = 1'b1;
`endif

    for (int i = 0; i < 11; i++) begin
      reset       = tbl[i].rst;
      a_in_valid  = tbl[i].av;
      a_out_ready = tbl[i].ar;
      a_in_bits   = mk_a(tbl[i].src);
      #1;
      chk($sformatf("tbl%0d a_in_ready", i), 128'(a_in_ready), 128'(tbl[i].e_rdy));
      chk($sformatf("tbl%0d a_out_valid", i), 128'(a_out_valid), 128'(tbl[i].e_vld));
      chk($sformatf("tbl%0d a_occupancy", i), 128'(a_occupancy), 128'(tbl[i].e_occ));
      if (tbl[i].e_vld)
        chk($sformatf("tbl%0d a_out_bits", i), 128'(a_out_bits), 128'(mk_a(tbl[i].e_src)));
      if (i == 1) begin
        chk("idle d_in_ready", 128'(d_in_ready), 128'(1));
        chk("idle d_out_valid", 128'(d_out_valid), 128'(0));
        chk("idle d_occupancy", 128'(d_occupancy), 128'(0));
      end
      step();
    end
    a_in_valid = 1'b0; a_out_ready = 1'b0;

    // D streaming at full rate
    dbase = 64'h0123_4567_89AB_CDEF;
    d_out_ready = 1'b1;
    for (int i = 0; i < 16; i++) begin
      d_in_valid = 1'b1;
      d_in_bits  = mk_d(dbase + 64'(i));
      #1;
      chk($sformatf("stream%0d d_in_ready", i), 128'(d_in_ready), 128'(1));
`ifdef TL_AD_BUFFER_FLOW_EN
      chk($sformatf("stream%0d d_out_valid", i), 128'(d_out_valid), 128'(1));
      chk($sformatf("stream%0d d_out_bits", i), 128'(d_out_bits), 128'(mk_d(dbase + 64'(i))));
      chk($sformatf("stream%0d d_occupancy", i), 128'(d_occupancy), 128'(0));
`else
      chk($sformatf("stream%0d d_out_valid", i), 128'(d_out_valid), 128'(i > 0));
      if (i > 0)
        chk($sformatf("stream%0d d_out_bits", i), 128'(d_out_bits), 128'(mk_d(dbase + 64'(i - 1))));
      chk($sformatf("stream%0d d_occupancy", i), 128'(d_occupancy), 128'(i > 0));
`endif
      step();
    end
    d_in_valid = 1'b0;
    step();
    d_out_ready = 1'b0;

    // Reset mid-burst discards buffered beats on both channels
    a_in_valid = 1'b1; a_in_bits = mk_a(4'd7);
    d_in_valid = 1'b1; d_in_bits = mk_d(64'hDEAD);
    step();
    d_in_valid = 1'b0;
    a_in_bits = mk_a(4'd8);
    step();
    a_in_valid = 1'b0;
    #1;
    chk("preload a_occupancy", 128'(a_occupancy), 128'(2));
    chk("preload d_occupancy", 128'(d_occupancy), 128'(1));
    reset = 1'b1;
    step();
    reset = 1'b0;
    #1;
    chk("post-reset a_out_valid", 128'(a_out_valid), 128'(0));
    chk("post-reset d_out_valid", 128'(d_out_valid), 128'(0));
    chk("post-reset a_occupancy", 128'(a_occupancy), 128'(0));
    chk("post-reset d_occupancy", 128'(d_occupancy), 128'(0));
    a_in_valid = 1'b1; a_in_bits = mk_a(4'd5);
    d_in_valid = 1'b1; d_in_bits = mk_d(64'hBEEF);
    step();
    a_in_valid = 1'b0; d_in_valid = 1'b0;
    #1;
    chk("post-reset first a beat", 128'(a_out_bits), 128'(mk_a(4'd5)));
    chk("post-reset first d beat", 128'(d_out_bits), 128'(mk_d(64'hBEEF)));
    chk("post-reset a_occupancy 1", 128'(a_occupancy), 128'(1));
    reset = 1'b1;
    step();
    reset = 1'b0;

    // Random traffic against queue model
    qa.delete(); qd.delete();
    pa_vld = 1'b0; pa_rdy = 1'b0; pa_bits = '0;
    pd_vld = 1'b0; pd_rdy = 1'b0; pd_bits = '0;
    for (int cyc = 0; cyc < 10000; cyc++) begin
      a_in_valid  = ($urandom_range(0, 99) < 60);
      a_out_ready = ($urandom_range(0, 99) < 50);
      a_in_bits   = 119'({$urandom, $urandom, $urandom, $urandom});
      d_in_valid  = ($urandom_range(0, 99) < 50);
      d_out_ready = ($urandom_range(0, 99) < 60);
      d_in_bits   = 79'({$urandom, $urandom, $urandom});
      #1;
`ifdef TL_AD_BUFFER_FLOW_EN
      ea_vld  = (qa.size() != 0) || a_in_valid;
      ea_bits = (qa.size() != 0) ? qa[0] : a_in_bits;
      ed_vld  = (qd.size() != 0) || d_in_valid;
      ed_bits = (qd.size() != 0) ? qd[0] : d_in_bits;
`else
      ea_vld  = (qa.size() != 0);
      ea_bits = ea_vld ? qa[0] : '0;
      ed_vld  = (qd.size() != 0);
      ed_bits = ed_vld ? qd[0] : '0;
`endif
      chk("rand a_in_ready", 128'(a_in_ready), 128'(qa.size() != AD));
      chk("rand a_out_valid", 128'(a_out_valid), 128'(ea_vld));
      chk("rand a_occupancy", 128'(a_occupancy), 128'(qa.size()));
      if (ea_vld) chk("rand a_out_bits", 128'(a_out_bits), 128'(ea_bits));
      if (pa_vld && !pa_rdy) chk("rand a stable", 128'(a_out_bits), 128'(pa_bits));
      chk("rand d_in_ready", 128'(d_in_ready), 128'(qd.size() != DD));
      chk("rand d_out_valid", 128'(d_out_valid), 128'(ed_vld));
      chk("rand d_occupancy", 128'(d_occupancy), 128'(qd.size()));
      if (ed_vld) chk("rand d_out_bits", 128'(d_out_bits), 128'(ed_bits));
      if (pd_vld && !pd_rdy) chk("rand d stable", 128'(d_out_bits), 128'(pd_bits));
      pa_vld = ea_vld; pa_rdy = a_out_ready; pa_bits = ea_bits;
      pd_vld = ed_vld; pd_rdy = d_out_ready; pd_bits = ed_bits;

      if (!(qa.size() == 0 && a_in_valid && a_out_ready && ea_vld)) begin
        logic do_enq;
        do_enq = a_in_valid && (qa.size() != AD);
        if (qa.size() != 0 && a_out_ready) void'(qa.pop_front());
        if (do_enq) qa.push_back(a_in_bits);
      end
      if (!(qd.size() == 0 && d_in_valid && d_out_ready && ed_vld)) begin
        logic do_enq;
        do_enq = d_in_valid && (qd.size() != DD);
        if (qd.size() != 0 && d_out_ready) void'(qd.pop_front());
        if (do_enq) qd.push_back(d_in_bits);
      end
      step();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
